pipeline_controller: RTL and testbench
======================================

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, meaning extra cycles IF/ID stays squashed after a taken branch (range 1-15).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, meaning width of the performance counters.
REQ-003 SHALL use one clock and an asynchronous, active-high reset; the ports are named clk and rst.
REQ-004 clk  in  1  clock, all state updates on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 idRs, idRt  in  5 each  source register numbers of the instruction in ID.
REQ-007 idUsesRs, idUsesRt  in  1 each  ID instruction reads rs / rt.
REQ-008 exWrNum, memWrNum, wbWrNum  in  5 each  destination register in EX / MEM / WB.
REQ-009 exRfWrEnable, memRfWrEnable, wbRfWrEnable  in  1 each  stage will write the register file.
REQ-010 memIsLoad, memIsStore  in  1 each  MEM-stage instruction accesses the data bus.
REQ-011 dataAck  in  1  data bus completes the current access this cycle.
REQ-012 memBrTaken  in  1  MEM-stage branch/jump redirects the PC.
REQ-013 pcStall, ifidStall  out  1 each  hold PC / IF-ID register.
REQ-014 idexBubble  out  1  load all-zero controls into ID-EX (NOP).
REQ-015 idexStall, exmemStall  out  1 each  hold ID-EX / EX-MEM registers.
REQ-016 memwbBubble  out  1  load zero controls into MEM-WB.
REQ-017 ifidFlush, idexFlush, exmemFlush  out  1 each  squash the corresponding register to NOP.
REQ-018 dataReq  out  1  data access request to the bus.
REQ-019 ctrlState  out  2  current state: 0 RUN, 1 MEM_WAIT, 2 FLUSH.
REQ-020 stallCount, flushCount  out  CNT_WIDTH each  performance counters.

Function
REQ-021 rawHaz SHALL be 1 when (idUsesRs and idRs!=0) or (idUsesRt and idRt!=0) matches any of exWrNum/memWrNum/wbWrNum whose RfWrEnable is 1; no forwarding exists.
REQ-022 dataReq SHALL equal (memIsLoad or memIsStore) in RUN and MEM_WAIT, and 0 in FLUSH.
REQ-023 memStall SHALL be dataReq and not dataAck; a same-cycle ack causes zero stall cycles.
REQ-024 On memStall, outputs SHALL be: pcStall, ifidStall, idexStall, exmemStall, memwbBubble all 1; flushes 0; idexBubble 0.
REQ-025 RUN->MEM_WAIT when memStall; MEM_WAIT stays until dataAck, then ->RUN (or ->FLUSH if memBrTaken also 1).
REQ-026 Accepted branch = memBrTaken and not memStall in RUN/MEM_WAIT: ifidFlush, idexFlush, exmemFlush SHALL be 1 that cycle, stalls 0; next state FLUSH with down-counter loaded to FLUSH_CYCLES.
REQ-027 In FLUSH: ifidFlush=1, idexBubble=1, all stalls 0, memBrTaken and rawHaz ignored; counter decrements each cycle; ->RUN in the cycle it reads 1.
REQ-028 RAW stall applies in RUN only, when no memStall and no accepted branch: pcStall=ifidStall=idexBubble=1, all other outputs 0.
REQ-029 Priority SHALL be memStall > accepted branch > rawHaz.
REQ-030 stallCount SHALL increment by 1 each cycle pcStall=1, saturating at all-ones.
REQ-031 flushCount SHALL increment by 1 per accepted branch, saturating at all-ones.
REQ-032 Unused state encoding 3 SHALL transition to RUN next cycle with all control outputs 0.
REQ-033 Control outputs SHALL be combinational from state and inputs; state and counters are registered.

Reset
REQ-034 rst SHALL immediately force state RUN, FLUSH counter 0, stallCount=flushCount=0, regardless of clk.
REQ-035 rst asserted mid-MEM_WAIT or mid-FLUSH SHALL abandon the operation; after release, behaviour follows RUN rules from current inputs.

Verification
REQ-036 rst pulse in MEM_WAIT -> ctrlState=0 and counters 0 before next clk edge.
REQ-037 idUsesRs=1, idRs=5, exWrNum=5, exRfWrEnable=1 -> pcStall=ifidStall=idexBubble=1, stallCount +1/cycle; idRs=0 -> no stall.
REQ-038 memIsLoad=1, dataAck low 3 cycles then high -> ctrlState 1 for 3 cycles, full pipe hold, memwbBubble=1, stallCount=3, release on ack cycle.
REQ-039 memBrTaken=1 in RUN, FLUSH_CYCLES=2 -> 3 flushes for 1 cycle, then ifidFlush=1 for 2 cycles, ctrlState 2 then 0, flushCount=1.
REQ-040 memIsStore=1, memBrTaken=1, dataAck=0 two cycles -> no flush while stalled; flush on ack cycle, then FLUSH.
REQ-041 rawHaz=1 concurrent with accepted branch -> flushes only, pcStall=0.

Source files
------------

// File: rtl/pipeline_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_controller
// Purpose  : Hazard and flow controller for a five-stage in-order pipeline
//            without forwarding. Detects RAW hazards against EX/MEM/WB writers,
//            holds the whole pipe while a data-bus access is outstanding, and
//            squashes the front end after a taken branch resolved in MEM.
//            Stall and flush events are counted in saturating counters.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            idRs/idRt/idUses*   - ID-stage source operands
//            *WrNum/*RfWrEnable  - EX/MEM/WB destination registers
//            memIsLoad/Store     - MEM-stage data-bus access
//            dataAck             - bus completes the access this cycle
//            memBrTaken          - MEM-stage redirect
//            *Stall/*Bubble/*Flush - pipeline register controls
//            dataReq             - data-bus request
//            ctrlState           - 0 RUN, 1 MEM_WAIT, 2 FLUSH
//            stallCount/flushCount - saturating performance counters
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_controller #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           idRs,
    input  logic [4:0]           idRt,
    input  logic                 idUsesRs,
    input  logic                 idUsesRt,
    input  logic [4:0]           exWrNum,
    input  logic [4:0]           memWrNum,
    input  logic [4:0]           wbWrNum,
    input  logic                 exRfWrEnable,
    input  logic                 memRfWrEnable,
    input  logic                 wbRfWrEnable,
    input  logic                 memIsLoad,
    input  logic                 memIsStore,
    input  logic                 dataAck,
    input  logic                 memBrTaken,
    output logic                 pcStall,
    output logic                 ifidStall,
    output logic                 idexBubble,
    output logic                 idexStall,
    output logic                 exmemStall,
    output logic                 memwbBubble,
    output logic                 ifidFlush,
    output logic                 idexFlush,
    output logic                 exmemFlush,
    output logic                 dataReq,
    output logic [1:0]           ctrlState,
    output logic [CNT_WIDTH-1:0] stallCount,
    output logic [CNT_WIDTH-1:0] flushCount
);

    localparam logic [1:0] c_STATE_RUN      = 2'd0;
    localparam logic [1:0] c_STATE_MEM_WAIT = 2'd1;
    localparam logic [1:0] c_STATE_FLUSH    = 2'd2;

    localparam logic [3:0]           c_FLUSH_LOAD = 4'(FLUSH_CYCLES);
    localparam logic [3:0]           c_FLUSH_ONE  = 4'd1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE    = 1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX    = '1;

    logic [1:0]           r_state;
    logic [1:0]           w_nextState;
    logic [3:0]           r_flushCnt;
    logic [3:0]           w_nextFlushCnt;
    logic [CNT_WIDTH-1:0] r_stallCount;
    logic [CNT_WIDTH-1:0] r_flushCount;

    logic w_rsHaz;
    logic w_rtHaz;
    logic w_rawHaz;
    logic w_busActive;
    logic w_memStall;
    logic w_accBranch;

    // Register 0 is hardwired zero, so it never creates a dependency.
    assign w_rsHaz = idUsesRs && (idRs != 5'd0) &&
                     ((exRfWrEnable  && (exWrNum  == idRs)) ||
                      (memRfWrEnable && (memWrNum == idRs)) ||
                      (wbRfWrEnable  && (wbWrNum  == idRs)));
    assign w_rtHaz = idUsesRt && (idRt != 5'd0) &&
                     ((exRfWrEnable  && (exWrNum  == idRt)) ||
                      (memRfWrEnable && (memWrNum == idRt)) ||
                      (wbRfWrEnable  && (wbWrNum  == idRt)));
    assign w_rawHaz = w_rsHaz || w_rtHaz;

    // The MEM instruction is squashed while in FLUSH, so it may not touch the bus.
    assign w_busActive = (r_state == c_STATE_RUN) || (r_state == c_STATE_MEM_WAIT);
    assign dataReq     = w_busActive && (memIsLoad || memIsStore);
    assign w_memStall  = dataReq && !dataAck;
    // A branch stuck behind a stalled access is taken only once the access completes.
    assign w_accBranch = w_busActive && memBrTaken && !w_memStall;

    // ------------------------------------------------------------------
    // State register, flush down-counter and performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_STATE_RUN;
            r_flushCnt <= 4'd0;
        end else begin
            r_state    <= w_nextState;
            r_flushCnt <= w_nextFlushCnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stallCount <= '0;
            r_flushCount <= '0;
        end else begin
            if (pcStall && (r_stallCount != c_CNT_MAX)) begin
                r_stallCount <= r_stallCount + c_CNT_ONE;
            end
            if (w_accBranch && (r_flushCount != c_CNT_MAX)) begin
                r_flushCount <= r_flushCount + c_CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState    = r_state;
        w_nextFlushCnt = r_flushCnt;
        case (r_state)
            c_STATE_RUN, c_STATE_MEM_WAIT: begin
                if (w_memStall) begin
                    w_nextState = c_STATE_MEM_WAIT;
                end else if (w_accBranch) begin
                    w_nextState    = c_STATE_FLUSH;
                    w_nextFlushCnt = c_FLUSH_LOAD;
                end else begin
                    w_nextState = c_STATE_RUN;
                end
            end
            c_STATE_FLUSH: begin
                // Leave in the cycle the counter reads 1; a zero count also exits
                // so the FSM can never lock up in FLUSH.
                if (r_flushCnt <= c_FLUSH_ONE) begin
                    w_nextState    = c_STATE_RUN;
                    w_nextFlushCnt = 4'd0;
                end else begin
                    w_nextFlushCnt = r_flushCnt - c_FLUSH_ONE;
                end
            end
            default: begin
                w_nextState    = c_STATE_RUN;
                w_nextFlushCnt = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: memStall > accepted branch > RAW hazard
    // ------------------------------------------------------------------
    always_comb begin
        pcStall     = 1'b0;
        ifidStall   = 1'b0;
        idexBubble  = 1'b0;
        idexStall   = 1'b0;
        exmemStall  = 1'b0;
        memwbBubble = 1'b0;
        ifidFlush   = 1'b0;
        idexFlush   = 1'b0;
        exmemFlush  = 1'b0;
        case (r_state)
            c_STATE_RUN, c_STATE_MEM_WAIT: begin
                if (w_memStall) begin
                    pcStall     = 1'b1;
                    ifidStall   = 1'b1;
                    idexStall   = 1'b1;
                    exmemStall  = 1'b1;
                    memwbBubble = 1'b1;
                end else if (w_accBranch) begin
                    ifidFlush  = 1'b1;
                    idexFlush  = 1'b1;
                    exmemFlush = 1'b1;
                end else if ((r_state == c_STATE_RUN) && w_rawHaz) begin
                    pcStall    = 1'b1;
                    ifidStall  = 1'b1;
                    idexBubble = 1'b1;
                end
            end
            c_STATE_FLUSH: begin
                ifidFlush  = 1'b1;
                idexBubble = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign ctrlState  = r_state;
    assign stallCount = r_stallCount;
    assign flushCount = r_flushCount;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_controller
// Purpose  : Self-checking bench for pipeline_controller. A behavioural model
//            predicts every output each cycle; directed scenarios add literal
//            expectations and random traffic exercises the rest.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_controller;

    localparam int FC   = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    idRs = '0, idRt = '0;
    logic          idUsesRs = 1'b0, idUsesRt = 1'b0;
    logic [4:0]    exWrNum = '0, memWrNum = '0, wbWrNum = '0;
    logic          exRfWrEnable = 1'b0, memRfWrEnable = 1'b0, wbRfWrEnable = 1'b0;
    logic          memIsLoad = 1'b0, memIsStore = 1'b0, dataAck = 1'b0, memBrTaken = 1'b0;
    logic          pcStall, ifidStall, idexBubble, idexStall, exmemStall, memwbBubble;
    logic          ifidFlush, idexFlush, exmemFlush, dataReq;
    logic [1:0]    ctrlState;
    logic [CW-1:0] stallCount, flushCount;

    pipeline_controller #(.FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .idRs(idRs), .idRt(idRt), .idUsesRs(idUsesRs), .idUsesRt(idUsesRt),
        .exWrNum(exWrNum), .memWrNum(memWrNum), .wbWrNum(wbWrNum),
        .exRfWrEnable(exRfWrEnable), .memRfWrEnable(memRfWrEnable), .wbRfWrEnable(wbRfWrEnable),
        .memIsLoad(memIsLoad), .memIsStore(memIsStore), .dataAck(dataAck), .memBrTaken(memBrTaken),
        .pcStall(pcStall), .ifidStall(ifidStall), .idexBubble(idexBubble),
        .idexStall(idexStall), .exmemStall(exmemStall), .memwbBubble(memwbBubble),
        .ifidFlush(ifidFlush), .idexFlush(idexFlush), .exmemFlush(exmemFlush),
        .dataReq(dataReq), .ctrlState(ctrlState),
        .stallCount(stallCount), .flushCount(flushCount)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;

    // Model state: mode uses the externally visible ctrlState numbering,
    // mLeft is the number of squash cycles still to come.
    int mMode = 0, mLeft = 0, mStall = 0, mFlush = 0;
    int nMode, nLeft, nStall, nFlush;
    logic [9:0] eCtl;

    wire [9:0] dutCtl = {pcStall, ifidStall, idexBubble, idexStall, exmemStall,
                         memwbBubble, ifidFlush, idexFlush, exmemFlush, dataReq};

    task automatic chk(input string name, input int got, input int want);
        nChecks++;
        if (got == want) nPass++;
        else $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    endtask

    // Field order of eCtl: pc, ifid, idexBubble, idexStall, exmemStall,
    // memwbBubble, ifidFlush, idexFlush, exmemFlush, dataReq.
    task automatic modelEval();
        int   wr [3];
        logic we [3];
        logic haz, busy, hold, branch;
        wr[0] = exWrNum;  wr[1] = memWrNum;  wr[2] = wbWrNum;
        we[0] = exRfWrEnable; we[1] = memRfWrEnable; we[2] = wbRfWrEnable;
        haz = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (we[k]) begin
                if (idUsesRs && idRs != 0 && int'(idRs) == wr[k]) haz = 1'b1;
                if (idUsesRt && idRt != 0 && int'(idRt) == wr[k]) haz = 1'b1;
            end
        end
        busy   = (mMode != 2) && (memIsLoad || memIsStore);
        hold   = busy && !dataAck;
        branch = (mMode != 2) && memBrTaken && !hold;
        if (hold)                    eCtl = 10'b1101110001;
        else if (branch)             eCtl = {9'b000000111, busy};
        else if (mMode == 2)         eCtl = 10'b0010001000;
        else if (mMode == 0 && haz)  eCtl = {9'b111000000, busy};
        else                         eCtl = {9'b0, busy};

        nStall = (eCtl[9] && mStall < CMAX) ? mStall + 1 : mStall;
        nFlush = (branch && mFlush < CMAX) ? mFlush + 1 : mFlush;
        nLeft  = mLeft;
        if (mMode == 2) begin
            nLeft = mLeft - 1;
            nMode = (nLeft == 0) ? 0 : 2;
        end else if (hold) begin
            nMode = 1;
        end else if (branch) begin
            nMode = 2;
            nLeft = FC;
        end else begin
            nMode = 0;
        end
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic checkModel();
        modelEval();
        chk("ctl", int'(dutCtl), int'(eCtl));
        chk("state", int'(ctrlState), mMode);
        chk("stallCount", int'(stallCount), mStall);
        chk("flushCount", int'(flushCount), mFlush);
    endtask

    task automatic advance();
        modelEval();
        @(posedge clk);
        #1;
        mMode = nMode; mLeft = nLeft; mStall = nStall; mFlush = nFlush;
    endtask

    task automatic cyc();
        settle();
        checkModel();
        advance();
    endtask

    // Asynchronous pulse between edges; effects must be visible before any clock edge.
    task automatic doReset();
        rst = 1'b1;
        #1;
        chk("rst_state", int'(ctrlState), 0);
        chk("rst_stall", int'(stallCount), 0);
        chk("rst_flush", int'(flushCount), 0);
        rst = 1'b0;
        mMode = 0; mLeft = 0; mStall = 0; mFlush = 0;
    endtask

    task automatic clearIn();
        idRs = '0; idRt = '0; idUsesRs = 1'b0; idUsesRt = 1'b0;
        exWrNum = '0; memWrNum = '0; wbWrNum = '0;
        exRfWrEnable = 1'b0; memRfWrEnable = 1'b0; wbRfWrEnable = 1'b0;
        memIsLoad = 1'b0; memIsStore = 1'b0; dataAck = 1'b0; memBrTaken = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        doReset();
        clearIn();
        cyc();

        // RAW hazard on rs from EX, counter growth, then register 0 is harmless
        idUsesRs = 1'b1; idRs = 5'd5; exWrNum = 5'd5; exRfWrEnable = 1'b1;
        settle(); checkModel();
        chk("raw_pc", int'(pcStall), 1);
        chk("raw_bubble", int'(idexBubble), 1);
        advance();
        settle(); checkModel();
        chk("raw_cnt1", int'(stallCount), 1);
        advance();
        settle(); checkModel();
        chk("raw_cnt2", int'(stallCount), 2);
        advance();
        idRs = 5'd0; exWrNum = 5'd0;
        settle(); checkModel();
        chk("raw_r0", int'(pcStall), 0);
        advance();
        // rt against WB, then writer disabled
        idUsesRs = 1'b0; idUsesRt = 1'b1; idRt = 5'd7; wbWrNum = 5'd7; wbRfWrEnable = 1'b1;
        settle(); checkModel();
        chk("raw_rt_wb", int'(ifidStall), 1);
        advance();
        wbRfWrEnable = 1'b0;
        settle(); checkModel();
        chk("raw_nowe", int'(pcStall), 0);
        advance();
        // Saturation of stallCount
        wbRfWrEnable = 1'b1;
        for (int i = 0; i < 20; i++) cyc();
        settle(); checkModel();
        chk("stall_sat", int'(stallCount), CMAX);
        advance();

        // Load waiting three cycles for ack
        doReset(); clearIn();
        memIsLoad = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle(); checkModel();
            chk("ld_mwb", int'(memwbBubble), 1);
            chk("ld_exm", int'(exmemStall), 1);
            chk("ld_state", int'(ctrlState), (i == 0) ? 0 : 1);
            advance();
        end
        dataAck = 1'b1;
        settle(); checkModel();
        chk("ld_ack_state", int'(ctrlState), 1);
        chk("ld_ack_pc", int'(pcStall), 0);
        chk("ld_ack_cnt", int'(stallCount), 3);
        advance();
        clearIn();
        settle(); checkModel();
        chk("ld_back_run", int'(ctrlState), 0);
        advance();

        // Reset pulse while in MEM_WAIT
        doReset(); clearIn();
        memIsLoad = 1'b1;
        cyc();
        settle(); checkModel();
        chk("mw_before_rst", int'(ctrlState), 1);
        doReset();
        advance();
        clearIn();
        cyc();

        // Taken branch in RUN with two squash cycles
        doReset(); clearIn();
        memBrTaken = 1'b1;
        settle(); checkModel();
        chk("br_flush3", {29'd0, ifidFlush, idexFlush, exmemFlush}, 7);
        chk("br_pc", int'(pcStall), 0);
        advance();
        for (int i = 0; i < 2; i++) begin
            settle(); checkModel();
            chk("fl_state", int'(ctrlState), 2);
            chk("fl_ifid", int'(ifidFlush), 1);
            chk("fl_idex", int'(idexFlush), 0);
            advance();
        end
        memBrTaken = 1'b0;
        settle(); checkModel();
        chk("fl_done", int'(ctrlState), 0);
        chk("fl_cnt", int'(flushCount), 1);
        advance();

        // Branch behind a stalled store
        doReset(); clearIn();
        memIsStore = 1'b1; memBrTaken = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle(); checkModel();
            chk("st_noflush", int'(exmemFlush), 0);
            chk("st_hold", int'(pcStall), 1);
            advance();
        end
        dataAck = 1'b1;
        settle(); checkModel();
        chk("st_ack_flush", int'(exmemFlush), 1);
        chk("st_ack_state", int'(ctrlState), 1);
        advance();
        clearIn();
        settle(); checkModel();
        chk("st_to_flush", int'(ctrlState), 2);
        advance();
        cyc();

        // RAW concurrent with branch: branch wins
        doReset(); clearIn();
        idUsesRs = 1'b1; idRs = 5'd5; exWrNum = 5'd5; exRfWrEnable = 1'b1; memBrTaken = 1'b1;
        settle(); checkModel();
        chk("rb_flush", int'(ifidFlush), 1);
        chk("rb_pc", int'(pcStall), 0);
        chk("rb_bubble", int'(idexBubble), 0);
        advance();

        // Randomized traffic
        doReset(); clearIn();
        for (int i = 0; i < 3000; i++) begin
            idRs = 5'($urandom_range(0, 7));
            idRt = 5'($urandom_range(0, 7));
            idUsesRs = 1'($urandom_range(0, 1));
            idUsesRt = 1'($urandom_range(0, 1));
            exWrNum  = 5'($urandom_range(0, 7));
            memWrNum = 5'($urandom_range(0, 7));
            wbWrNum  = 5'($urandom_range(0, 7));
            exRfWrEnable  = ($urandom_range(0, 2) == 0);
            memRfWrEnable = ($urandom_range(0, 2) == 0);
            wbRfWrEnable  = ($urandom_range(0, 2) == 0);
            memIsLoad  = ($urandom_range(0, 3) == 0);
            memIsStore = ($urandom_range(0, 5) == 0);
            dataAck    = ($urandom_range(0, 1) == 0);
            memBrTaken = ($urandom_range(0, 4) == 0);
            settle();
            checkModel();
            if ($urandom_range(0, 59) == 0) doReset();
            advance();
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
